// File: rtl/bcd_serial_subtractor.sv
// Packed-BCD serial subtractor: D = A - B - Bin, one decimal digit per clock, LSD first.
// Start/ready/done handshake; a borrow out of the top digit leaves D in ten's complement.
module bcd_serial_subtractor #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  bin,
  output logic                  ready,
  output logic                  done,
  output logic [4*DIGITS-1:0]   d,
  output logic                  bout,
  output logic                  err
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t          state, state_next;
  logic [W-1:0]    a_q, b_q, res_q, res_next;
  logic [IW-1:0]   idx;
  logic            borrow, borrow_next;
  logic            in_bad, last;
  logic [3:0]      a_dig, b_dig, dig;
  logic [4:0]      t, t_adj;

  // Any non-decimal nibble on the operands sends the request straight to FINISH.
  always_comb begin
    in_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) in_bad = 1'b1;
    end
  end

  // One digit of the subtraction; bit 4 of t is the sign of a_i - b_i - borrow.
  always_comb begin
    a_dig       = a_q[idx*4 +: 4];
    b_dig       = b_q[idx*4 +: 4];
    t           = {1'b0, a_dig} - {1'b0, b_dig} - {4'b0000, borrow};
    t_adj       = t + 5'd10;
    borrow_next = t[4];
    dig         = t[4] ? t_adj[3:0] : t[3:0];
    // NOTE: blocking assignments here build one combinational value; a default
    // for every output of this block up front is what keeps latches out.
    res_next             = res_q;
    res_next[idx*4 +: 4] = dig;
    last                 = (idx == IW'(DIGITS - 1));
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = in_bad ? FINISH : RUN;
      RUN:     if (last)  state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign ready = (state == IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      idx    <= '0;
      borrow <= 1'b0;
      d      <= '0;
      bout   <= 1'b0;
      err    <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q    <= a;
            b_q    <= b;
            res_q  <= '0;
            idx    <= '0;
            borrow <= bin;
            if (in_bad) begin
              err  <= 1'b1;
              d    <= '0;
              bout <= 1'b0;
              done <= 1'b1;
            end else begin
              // D and Bout keep the previous result until the new FINISH.
              err  <= 1'b0;
            end
          end
        end
        RUN: begin
          res_q  <= res_next;
          borrow <= borrow_next;
          idx    <= idx + 1'b1;
          if (last) begin
            d    <= res_next;
            bout <= borrow_next;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
